// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV sequencer beside the E-stage ALU; owns HI/LO and raises the D-stage stall.
// Results come from latched operands and are written into HI/LO on the final busy cycle.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_a_neg = r_signed & r_a[31];
  assign w_b_neg = r_signed & r_b[31];

  // Low 64 bits of the product of the extended operands give both signed and unsigned results.
  assign w_a_ext = {{32{w_a_neg}}, r_a};
  assign w_b_ext = {{32{w_b_neg}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_a_mag    = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_b_mag    = w_b_neg ? (~r_b + 32'd1) : r_b;
  assign w_div_zero = (r_b == 32'd0);
  assign w_b_div    = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_div;
  assign w_r_mag    = w_a_mag % w_b_div;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= ~op[0];
                r_busy   <= 1'b1;
                if (op[1]) begin
                  r_cnt   <= 4'(DIV_CYCLES);
                  r_state <= S_DIV;
                end else begin
                  r_cnt   <= 4'(MULT_CYCLES);
                  r_state <= S_MUL;
                end
              end
              3'd4:    r_hi <= a;
              3'd5:    r_lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (r_state == S_MUL) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = d_md_use & (start | r_busy);

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, hand sequences, randomized model compare.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one instruction, then measure busy length and count done pulses.
  task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output int pulses);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    pulses = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (done) pulses++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
  endtask

  // Reference model: MIPS HI/LO semantics computed with native integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] mhi, inout logic [31:0] mlo);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (o)
      3'd0: begin sp = longint'(sx) * longint'(sy); mhi = sp[63:32]; mlo = sp[31:0]; end
      3'd1: begin up = longint'(x) * longint'(y); mhi = up[63:32]; mlo = up[31:0]; end
      3'd2: begin
        if (y == 0) begin end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin mlo = x; mhi = 32'd0; end
        else begin mlo = 32'(sx / sy); mhi = 32'(sx % sy); end
      end
      3'd3: if (y != 0) begin mlo = x / y; mhi = x % y; end
      3'd4: mhi = x;
      3'd5: mlo = x;
      default: ;
    endcase
  endtask

  int          cyc, pulses, exp_cyc;
  logic [31:0] m_hi, m_lo, x, y;
  logic [2:0]  o;

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd7,         32'd0,         10, 32'h0000_0011, 32'h0000_0022};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        10, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8] = '{3'd2, 32'd5,         32'd0,         10, 32'h0000_0011, 32'h0000_0022};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; d_md_use = 1'b1;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    d_md_use = 1'b0;

    // Directed table, each with HI/LO preloaded so divide-by-zero retention is visible.
    for (int i = 0; i < 9; i++) begin
      run_md(3'd4, 32'h11, 32'd0, cyc, pulses);
      run_md(3'd5, 32'h22, 32'd0, cyc, pulses);
      run_md(vecs[i].op, vecs[i].a, vecs[i].b, cyc, pulses);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
      check($sformatf("vec%0d_done", i), 64'(pulses), 64'd1);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // Reserved opcode leaves everything alone.
    run_md(3'd6, 32'h1234, 32'h5678, cyc, pulses);
    check("op6_busy", 64'(cyc), 64'd0);
    check("op6_done", 64'(pulses), 64'd0);
    check("op6_hi", 64'(hi), 64'h11);
    check("op6_lo", 64'(lo), 64'h22);

    // MTHI held asserted throughout a DIVU, including the edge busy falls.
    @(negedge clk);
    d_md_use = 1'b1;
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    #1 check("stall_on_start", 64'(stall), 64'd1);
    @(negedge clk);
    op = 3'd4; a = 32'hDEAD; b = 32'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      #1 check($sformatf("stall_busy%0d", cyc), 64'(stall), 64'd1);
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    check("stall_div_cycles", 64'(cyc), 64'd10);
    check("stall_fall", 64'(stall), 64'd0);
    check("stall_done_seen", 64'(done), 64'd1);
    check("mt_ignored_hi", 64'(hi), 64'd2);
    check("mt_ignored_lo", 64'(lo), 64'd14);
    d_md_use = 1'b0;

    // Randomized stream against the reference model.
    m_hi = hi;
    m_lo = lo;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 20);
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
      exp_cyc = (o < 3'd2) ? 5 : ((o < 3'd4) ? 10 : 0);
      run_md(o, x, y, cyc, pulses);
      model(o, x, y, m_hi, m_lo);
      check($sformatf("rnd%0d_op%0d_cycles", i, o), 64'(cyc), 64'(exp_cyc));
      check($sformatf("rnd%0d_op%0d_done", i, o), 64'(pulses), (o < 3'd4) ? 64'd1 : 64'd0);
      check($sformatf("rnd%0d_op%0d_hi", i, o), 64'(hi), 64'(m_hi));
      check($sformatf("rnd%0d_op%0d_lo", i, o), 64'(lo), 64'(m_lo));
    end

    // Asynchronous reset on the third busy cycle of a MULT.
    run_md(3'd4, 32'hABCD, 32'd0, cyc, pulses);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    cyc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) cyc++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    check("arst_no_busy", 64'(cyc), 64'd0);
    check("arst_hi_after", 64'(hi), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
